// File: rtl/hack_program_counter.sv
// Hack CPU program counter: WIDTH-bit instruction address that clears, loads,
// increments or holds each cycle, plus a one-cycle flag marking an all-ones-to-zero step.
module hack_program_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             LOAD,
    input  logic             INC,
    input  logic             CLR,
    output logic [WIDTH-1:0] OUT,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             all_ones;

    assign all_ones = &out_reg;

    // Fixed priority CLR > LOAD > INC > hold; losing commands have no effect.
    always_comb begin
        out_next  = out_reg;
        wrap_next = 1'b0;
        if (CLR) begin
            out_next = '0;
        end else if (LOAD) begin
            out_next = IN;
        end else if (INC) begin
            out_next  = out_reg + ONE;
            wrap_next = all_ones;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            out_reg  <= out_next;
            wrap_reg <= wrap_next;
        end
    end

    assign OUT  = out_reg;
    assign WRAP = wrap_reg;

endmodule

// File: tb/tb_hack_program_counter.sv
// Directed and model-checked bench for hack_program_counter at WIDTH=16 and WIDTH=4.
module tb_hack_program_counter;

    logic        CLK;
    logic        RST;
    logic [15:0] IN;
    logic        LOAD;
    logic        INC;
    logic        CLR;
    logic [15:0] OUT;
    logic        WRAP;

    logic        rst4;
    logic [3:0]  in4;
    logic        load4;
    logic        inc4;
    logic        clr4;
    logic [3:0]  out4;
    logic        wrap4;

    int vectors;
    int miscompares;

    hack_program_counter #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .IN(IN), .LOAD(LOAD), .INC(INC), .CLR(CLR),
        .OUT(OUT), .WRAP(WRAP)
    );

    hack_program_counter #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RST(rst4), .IN(in4), .LOAD(load4), .INC(inc4), .CLR(clr4),
        .OUT(out4), .WRAP(wrap4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command just after an edge, then sample 1 time unit after the next edge.
    task automatic apply(input logic c, input logic l, input logic i, input logic [15:0] d);
        CLR  = c;
        LOAD = l;
        INC  = i;
        IN   = d;
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] out_m;
    logic        wrap_m;
    logic [15:0] held;
    logic        rc, rl, ri;
    logic [15:0] rd;

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST = 1'b1; CLR = 1'b0; LOAD = 1'b0; INC = 1'b0; IN = 16'h0;
        rst4 = 1'b1; clr4 = 1'b0; load4 = 1'b0; inc4 = 1'b0; in4 = 4'h0;

        #3;
        chk("reset_out", 32'(OUT), 32'h0);
        chk("reset_wrap", 32'(WRAP), 32'h0);
        RST = 1'b0;

        // Asynchronous reset mid-cycle, then count up after release
        apply(1'b0, 1'b1, 1'b0, 16'h1234);
        chk("load_1234", 32'(OUT), 32'h1234);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_out", 32'(OUT), 32'h0);
        chk("async_rst_wrap", 32'(WRAP), 32'h0);
        RST = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            apply(1'b0, 1'b0, 1'b1, 16'h0);
            chk("post_rst_inc", 32'(OUT), 32'(k));
        end

        // Priority
        apply(1'b0, 1'b1, 1'b0, 16'h0010);
        chk("load_0010", 32'(OUT), 32'h0010);
        apply(1'b1, 1'b1, 1'b1, 16'h00FF);
        chk("prio_clr", 32'(OUT), 32'h0000);
        apply(1'b0, 1'b1, 1'b1, 16'h00FF);
        chk("prio_load_over_inc", 32'(OUT), 32'h00FF);
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        chk("inc_to_0100", 32'(OUT), 32'h0100);
        chk("inc_to_0100_wrap", 32'(WRAP), 32'h0);

        // Wrap
        apply(1'b0, 1'b1, 1'b0, 16'hFFFF);
        chk("load_ffff", 32'(OUT), 32'hFFFF);
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        chk("wrap_out", 32'(OUT), 32'h0000);
        chk("wrap_flag", 32'(WRAP), 32'h1);
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        chk("after_wrap_out", 32'(OUT), 32'h0001);
        chk("after_wrap_flag", 32'(WRAP), 32'h0);

        // Wrap followed by hold: flag must drop
        apply(1'b0, 1'b1, 1'b0, 16'hFFFF);
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        chk("wrap2_flag", 32'(WRAP), 32'h1);

        // Hold with IN toggling
        held = OUT;
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 1'b0, 1'b0, 16'($urandom));
            chk("hold_out", 32'(OUT), 32'(held));
            chk("hold_wrap", 32'(WRAP), 32'h0);
        end

        // WIDTH=4 instance: 16 increments walk 1..15 then 0
        #2 rst4 = 1'b0;
        inc4 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge CLK);
            #1;
            chk("w4_out", 32'(out4), 32'(k % 16));
            chk("w4_wrap", 32'(wrap4), (k == 16) ? 32'h1 : 32'h0);
        end
        inc4 = 1'b0;
        @(posedge CLK);
        #1;
        chk("w4_wrap_drop", 32'(wrap4), 32'h0);

        // Random regression against a priority reference model
        out_m  = OUT;
        wrap_m = WRAP;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                RST = 1'b1;
                #2;
                out_m  = 16'h0;
                wrap_m = 1'b0;
                chk("rnd_async_rst", 32'(OUT), 32'h0);
                RST = 1'b0;
            end
            rc = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 3) == 0);
            ri = ($urandom_range(0, 1) == 0);
            rd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            apply(rc, rl, ri, rd);
            if (rc) begin
                out_m = 16'h0; wrap_m = 1'b0;
            end else if (rl) begin
                out_m = rd; wrap_m = 1'b0;
            end else if (ri) begin
                wrap_m = (out_m == 16'hFFFF);
                out_m  = out_m + 16'h1;
            end else begin
                wrap_m = 1'b0;
            end
            chk("rnd_out", 32'(OUT), 32'(out_m));
            chk("rnd_wrap", 32'(WRAP), 32'(wrap_m));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
